// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction FIFO feeding a registered IF/ID stage with stall/flush handling.
// Optional FETCH_QUEUE_STATS_EN adds saturating BUBBLE_CNT and FULL_CNT counters.
module fetch_queue #(
    parameter int          DEPTH   = 4,
    parameter logic [31:0] NOP_INS = 32'h00000013
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     FETCH_VALID,
    input  logic [31:0]              FETCH_INS,
    input  logic [31:0]              FETCH_PC,
    output logic                     FETCH_READY,
    input  logic                     INS_CACHE_READY,
    input  logic                     STALL_ENABLE,
    input  logic                     DATA_CACHE_READY,
    input  logic                     EXSTAGE_STALLED,
    input  logic                     FLUSH,
    output logic [31:0]              INSTRUCTION,
    output logic [31:0]              PC_ID,
    output logic                     INS_VALID,
    output logic [$clog2(DEPTH):0]   COUNT
`ifdef FETCH_QUEUE_STATS_EN
   ,output logic [31:0]              BUBBLE_CNT,
    output logic [31:0]              FULL_CNT
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   ins_mem [DEPTH];
    logic [31:0]   pc_mem  [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          advance, push, empty, pop, bypass, wr;

    always_comb begin
        FETCH_READY = COUNT != CW'(DEPTH);
        advance     = STALL_ENABLE & DATA_CACHE_READY & !EXSTAGE_STALLED;
        push        = FETCH_VALID & INS_CACHE_READY & FETCH_READY;
        empty       = COUNT == '0;
        pop         = advance & !empty;
        // An empty queue hands a fresh fetch straight to decode instead of storing it
        bypass      = advance & empty & push;
        wr          = push & !bypass & !FLUSH;
    end

    always_ff @(posedge CLK)
        if (wr) begin
            ins_mem[wr_ptr] <= FETCH_INS;
            pc_mem[wr_ptr]  <= FETCH_PC;
        end

    always_ff @(posedge CLK)
        if (!RSTN) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            COUNT       <= '0;
            INSTRUCTION <= NOP_INS;
            PC_ID       <= '0;
            INS_VALID   <= 1'b0;
        end else if (FLUSH) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            COUNT       <= '0;
            INSTRUCTION <= NOP_INS;
            INS_VALID   <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            COUNT <= COUNT + CW'(wr) - CW'(pop);
            if (advance) begin
                INSTRUCTION <= pop ? ins_mem[rd_ptr] : bypass ? FETCH_INS : NOP_INS;
                PC_ID       <= pop ? pc_mem[rd_ptr] : bypass ? FETCH_PC : PC_ID;
                INS_VALID   <= pop | bypass;
            end
        end

`ifdef FETCH_QUEUE_STATS_EN
    always_ff @(posedge CLK)
        if (!RSTN) begin
            BUBBLE_CNT <= '0;
            FULL_CNT   <= '0;
        end else begin
            if (advance & empty & !push & !FLUSH & BUBBLE_CNT != 32'hFFFFFFFF)
                BUBBLE_CNT <= BUBBLE_CNT + 1'b1;
            if (!FETCH_READY & FULL_CNT != 32'hFFFFFFFF)
                FULL_CNT <= FULL_CNT + 1'b1;
        end
`endif
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer and IF/ID pipeline register between the instruction cache/fetch unit and the decode stage.
- Absorbs fetch-vs-decode rate mismatch in a small circular FIFO.
- Presents one registered instruction plus PC per cycle to decode.
- Honours the pipeline stall conditions (decode STALL_ENABLE, DATA_CACHE_READY, EXSTAGE_STALLED) and FLUSH from branch resolution.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- NOP_INS, 32'h00000013, bubble instruction (addi x0,x0,0) driven on INSTRUCTION when no valid instruction is present.

Ports:
- CLK  input  1  system clock, rising edge.
- RSTN  input  1  synchronous active-low reset.
- FETCH_VALID  input  1  fetch unit has an instruction this cycle.
- FETCH_INS  input  32  fetched instruction word.
- FETCH_PC  input  32  PC of FETCH_INS.
- FETCH_READY  output  1  queue can accept a push this cycle.
- INS_CACHE_READY  input  1  I-cache has returned data; a push is qualified by FETCH_VALID & INS_CACHE_READY.
- STALL_ENABLE  input  1  from decode; 1 = decode may advance, 0 = hazard stall.
- DATA_CACHE_READY  input  1  D-cache not stalling the pipe.
- EXSTAGE_STALLED  input  1  execute stage (multiplier) busy.
- FLUSH  input  1  discard all queued and IF/ID contents.
- INSTRUCTION  output  32  instruction presented to decode.
- PC_ID  output  32  PC of INSTRUCTION.
- INS_VALID  output  1  INSTRUCTION is a real instruction, not a bubble.
- COUNT  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clocking: single clock CLK; RSTN is synchronous, active low, sampled on the CLK rising edge.
- Reset values: queue empty, COUNT=0, read/write pointers 0, INSTRUCTION=NOP_INS, PC_ID=0, INS_VALID=0. FETCH_READY=1 combinationally once out of reset.
- Reset mid-operation: all entries are discarded regardless of other inputs.
- ADVANCE = STALL_ENABLE & DATA_CACHE_READY & !EXSTAGE_STALLED (combinational).
- PUSH = FETCH_VALID & INS_CACHE_READY & FETCH_READY.
- FETCH_READY = (COUNT != DEPTH). It is purely occupancy-based; there is no same-cycle pop credit.
- IF/ID register update on an ADVANCE cycle:
  - Queue non-empty: load head entry, pop, INS_VALID<=1.
  - Queue empty and PUSH: bypass FETCH_INS/FETCH_PC straight into IF/ID with INS_VALID<=1; nothing is written to the FIFO.
  - Queue empty and no PUSH: INSTRUCTION<=NOP_INS, INS_VALID<=0, PC_ID holds.
- Not ADVANCE: IF/ID register holds all three outputs unchanged. A PUSH still writes the FIFO.
- Latency: an instruction pushed into an empty queue during an ADVANCE cycle appears on INSTRUCTION on the next cycle (1 cycle). Otherwise it waits behind older entries, strictly in order.
- Simultaneous PUSH and pop (non-empty, not full): COUNT unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- FLUSH has priority over everything except reset:
  - Pointers and COUNT go to 0.
  - INSTRUCTION<=NOP_INS, INS_VALID<=0, PC_ID holds.
  - A PUSH in the flush cycle is dropped; the fetch unit re-fetches from the redirect target.
- FLUSH while stalled: the flush still takes effect; the stall does not protect IF/ID contents.
- Full: FETCH_READY=0 and FETCH_VALID is ignored. The fetch unit must hold its data; the queue never overwrites.
- Empty with no ADVANCE: outputs hold (a stalled bubble stays a bubble).

Optional Feature:
- Macro FETCH_QUEUE_STATS_EN.
- When defined:
  - Adds output BUBBLE_CNT [31:0]. It increments on each ADVANCE cycle where a bubble is issued (empty queue, no PUSH, no FLUSH), saturating at 32'hFFFFFFFF.
  - Adds output FULL_CNT [31:0]. It increments each cycle COUNT==DEPTH, also saturating.
  - Both counters reset to 0 on RSTN=0; FLUSH does not clear them.
- When undefined: neither port nor counter logic exists, and behaviour is otherwise identical.

Test Plan:
- Reset: hold RSTN=0 for 2 cycles with FETCH_VALID=1 -> INSTRUCTION=32'h00000013, INS_VALID=0, COUNT=0, PC_ID=0; after release FETCH_READY=1.
- Bypass: empty queue, ADVANCE=1, push INS=32'h00500093 PC=32'h100 at cycle t -> at t+1 INSTRUCTION=32'h00500093, PC_ID=32'h100, INS_VALID=1, COUNT=0.
- Fill/stall: STALL_ENABLE=0, push PCs 0x0,0x4,0x8,0xC -> COUNT=4, FETCH_READY=0; a 5th push at 0x10 is ignored. Release the stall -> INSTRUCTION sequence 0x0,0x4,0x8,0xC, one per cycle, then NOP with INS_VALID=0.
- Flush: COUNT=3, assert FLUSH together with a push of PC 0x40 -> next cycle COUNT=0, INS_VALID=0, INSTRUCTION=NOP_INS; the PC 0x40 instruction is never issued.
- Stall sources: queue holding 2 entries, pulse EXSTAGE_STALLED=1 for 3 cycles, then DATA_CACHE_READY=0 for 2 cycles -> INSTRUCTION/PC_ID constant throughout; COUNT drops only on cycles with ADVANCE=1.
- Wrap plus stats (FETCH_QUEUE_STATS_EN): 10 pushes with 1-cycle-delayed pops -> pointers wrap, order preserved; 5 ADVANCE cycles with an empty queue -> BUBBLE_CNT=5.
